// File: rtl/datapath_pkg.sv
// Shared types and encodings for the datapath controller: FSM states,
// instruction opcodes, ALU and shifter encodings, and the decoded-instruction record.
package datapath_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_MOV_IMM = 3'd1,
        CLS_MOV_REG = 3'd2,
        CLS_MVN     = 3'd3,
        CLS_ADD     = 3'd4,
        CLS_CMP     = 3'd5,
        CLS_AND     = 3'd6
    } instr_class_t;

    typedef struct packed {
        logic [2:0]   opcode;
        logic [1:0]   op;
        logic [2:0]   rn;
        logic [2:0]   rd;
        logic [1:0]   sh;
        logic [2:0]   rm;
        logic [15:0]  imm_ext;
        instr_class_t cls;
    } dec_t;

    function automatic logic [15:0] sign_ext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Combinational instruction decoder: splits the latched instruction into
// register/shift fields, sign-extends imm8 and classifies the operation.
module instr_dec
    import datapath_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);

    always_comb begin
        dec         = '0;
        dec.opcode  = ir[15:13];
        dec.op      = ir[12:11];
        dec.rn      = ir[10:8];
        dec.rd      = ir[7:5];
        dec.sh      = ir[4:3];
        dec.rm      = ir[2:0];
        dec.imm_ext = sign_ext8(ir[7:0]);
        dec.cls     = CLS_ILLEGAL;

        // Anything not matched below falls back to illegal and is dropped by the FSM.
        if (ir[15:13] == OPC_MOV) begin
            case (ir[12:11])
                OP_MOV_IMM: dec.cls = CLS_MOV_IMM;
                OP_MOV_REG: dec.cls = CLS_MOV_REG;
                default:    dec.cls = CLS_ILLEGAL;
            endcase
        end else if (ir[15:13] == OPC_ALU) begin
            case (ir[12:11])
                OP_ADD:  dec.cls = CLS_ADD;
                OP_CMP:  dec.cls = CLS_CMP;
                OP_AND:  dec.cls = CLS_AND;
                default: dec.cls = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Moore FSM sequencing the datapath: latches an instruction in WAIT, then
// steps through operand fetch, execute and write-back according to its class.
module datapath_ctrl
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic [15:0] instr,
    output logic        w,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic        write,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [15:0] imm_out
);

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    dec_t        dec;

    instr_dec u_instr_dec (
        .ir  (ir),
        .dec (dec)
    );

    // The instruction register only loads on an accepted start, so s/instr are ignored elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && s) begin
                ir <= instr;
            end
        end
    end

    always_comb begin
        next_state = state;
        w          = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = 1'b0;
        write      = 1'b0;
        ALUop      = ALU_ADD;
        shift      = SH_NONE;
        readnum    = 3'd0;
        writenum   = 3'd0;
        imm_out    = 16'd0;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                case (dec.cls)
                    CLS_MOV_IMM:          next_state = S_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN: next_state = S_GET_B;
                    CLS_ADD, CLS_CMP,
                    CLS_AND:              next_state = S_GET_A;
                    default:              next_state = S_WAIT;
                endcase
            end

            S_GET_A: begin
                readnum    = dec.rn;
                loada      = 1'b1;
                next_state = S_GET_B;
            end

            S_GET_B: begin
                readnum    = dec.rm;
                loadb      = 1'b1;
                next_state = S_EXEC;
            end

            // MOV reg passes B through an ADD with A forced to zero via asel.
            S_EXEC: begin
                shift = dec.sh;
                ALUop = (dec.opcode == OPC_ALU) ? dec.op : ALU_ADD;
                asel  = (dec.cls == CLS_MOV_REG) || (dec.cls == CLS_MVN);
                if (dec.cls == CLS_CMP) begin
                    loads      = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    loadc      = 1'b1;
                    next_state = S_WRITE_REG;
                end
            end

            S_WRITE_REG: begin
                write      = 1'b1;
                writenum   = dec.rd;
                next_state = S_WAIT;
            end

            S_WRITE_IMM: begin
                vsel       = 1'b1;
                write      = 1'b1;
                writenum   = dec.rn;
                imm_out    = dec.imm_ext;
                next_state = S_WAIT;
            end

            default: next_state = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Randomized self-checking bench for datapath_ctrl; expected per-cycle outputs
// come from an instruction-level model of what each instruction should do.
module tb_datapath_ctrl;

    typedef struct packed {
        logic        w;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic        vsel;
        logic        write;
        logic [1:0]  ALUop;
        logic [1:0]  shift;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [15:0] imm_out;
    } outs_t;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic [15:0] instr;
    outs_t       obs;

    int    checkCount;
    int    errorCount;
    outs_t expTrace [0:7];
    int    expLen;
    outs_t idleVec;

    datapath_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .instr    (instr),
        .w        (obs.w),
        .loada    (obs.loada),
        .loadb    (obs.loadb),
        .loadc    (obs.loadc),
        .loads    (obs.loads),
        .asel     (obs.asel),
        .bsel     (obs.bsel),
        .vsel     (obs.vsel),
        .write    (obs.write),
        .ALUop    (obs.ALUop),
        .shift    (obs.shift),
        .readnum  (obs.readnum),
        .writenum (obs.writenum),
        .imm_out  (obs.imm_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input outs_t got, input outs_t exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction-level model: the sequence of output vectors an instruction
    // should produce on the cycles following its acceptance.
    function automatic void buildTrace(input logic [15:0] i);
        logic [2:0] opc;
        logic [1:0] op;
        logic       movImm, movReg, mvn, useA, isCmp;
        outs_t      v;
        opc    = i[15:13];
        op     = i[12:11];
        movImm = (opc == 3'b110) && (op == 2'b10);
        movReg = (opc == 3'b110) && (op == 2'b00);
        mvn    = (opc == 3'b101) && (op == 2'b11);
        useA   = (opc == 3'b101) && (op != 2'b11);
        isCmp  = (opc == 3'b101) && (op == 2'b01);
        expLen = 0;
        expTrace[expLen++] = '0;
        if (movImm) begin
            v = '0;
            v.vsel = 1'b1;
            v.write = 1'b1;
            v.writenum = i[10:8];
            v.imm_out = {{8{i[7]}}, i[7:0]};
            expTrace[expLen++] = v;
        end else if (movReg || mvn || useA) begin
            if (useA) begin
                v = '0;
                v.readnum = i[10:8];
                v.loada = 1'b1;
                expTrace[expLen++] = v;
            end
            v = '0;
            v.readnum = i[2:0];
            v.loadb = 1'b1;
            expTrace[expLen++] = v;
            v = '0;
            v.shift = i[4:3];
            v.ALUop = movReg ? 2'b00 : op;
            v.asel = movReg || mvn;
            v.loads = isCmp;
            v.loadc = !isCmp;
            expTrace[expLen++] = v;
            if (!isCmp) begin
                v = '0;
                v.write = 1'b1;
                v.writenum = i[7:5];
                expTrace[expLen++] = v;
            end
        end
    endfunction

    // Accept one instruction after a few idle cycles, then follow its trace while
    // driving noise (or a held-high start) that the controller must ignore.
    task automatic applyStimulus(input logic [15:0] i, input int gap, input bit holdS,
                                 input int resetAt);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            checkOutput("idle_gap", obs, idleVec);
            s     = 1'b0;
            instr = 16'($urandom);
        end
        @(negedge clk);
        checkOutput($sformatf("pre_%04h", i), obs, idleVec);
        buildTrace(i);
        s     = 1'b1;
        instr = i;
        for (int k = 0; k < expLen; k++) begin
            @(negedge clk);
            checkOutput($sformatf("i%04h_c%0d", i, k), obs, expTrace[k]);
            s     = holdS ? 1'b1 : 1'($urandom);
            instr = holdS ? 16'hD32A : 16'($urandom);
            if (k == resetAt) begin
                #2 rst_n = 1'b0;
                #1 checkOutput("rst_async", obs, idleVec);
                s = 1'b1;
                @(negedge clk);
                checkOutput("rst_held", obs, idleVec);
                s     = 1'b0;
                rst_n = 1'b1;
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    checkOutput("rst_after", obs, idleVec);
                end
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] r;
        checkCount = 0;
        errorCount = 0;
        idleVec    = '0;
        idleVec.w  = 1'b1;
        rst_n      = 1'b0;
        s          = 1'b1;
        instr      = 16'hA543;
        #1 checkOutput("reset", obs, idleVec);
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", obs, idleVec);
        s     = 1'b0;
        rst_n = 1'b1;

        applyStimulus(16'hD32A, 1, 1'b0, -1);
        applyStimulus(16'hD1FF, 0, 1'b0, -1);
        applyStimulus(16'hA543, 0, 1'b0, -1);
        applyStimulus(16'hAD0B, 2, 1'b0, -1);
        applyStimulus(16'hE000, 0, 1'b0, -1);
        applyStimulus(16'hA543, 0, 1'b1, -1);
        applyStimulus(16'hD32A, 0, 1'b0, -1);
        applyStimulus(16'hC047, 1, 1'b0, -1);
        applyStimulus(16'hBCF1, 0, 1'b0, -1);
        applyStimulus(16'hA543, 0, 1'b0, 2);
        applyStimulus(16'hD32A, 0, 1'b0, -1);

        for (int n = 0; n < 200; n++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 3))
                0: r[15:13] = 3'b110;
                1, 2: r[15:13] = 3'b101;
                default: ;
            endcase
            applyStimulus(r, $urandom_range(0, 2), 1'($urandom_range(0, 7) == 0), -1);
        end

        @(negedge clk);
        checkOutput("final_idle", obs, idleVec);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
